// File: rtl/ti_prince_pkg.sv
// Shared constants, share-word type and Q294 functions for the threshold
// implemented PRINCE S-box datapath. The Q294 representative used here is
// y0 = x0^x3, y1 = x1, y2 = x2^x0x1^x1x3, y3 = x3^x0x2^x2x3 (bit 0 = LSB).
package ti_prince_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int SHARES          = 3;
    localparam int DEFAULT_NIBBLES = 16;

    typedef logic [NIBBLE_W-1:0]                 nibble_t;
    typedef logic [DEFAULT_NIBBLES*NIBBLE_W-1:0] share_word_t;

    // Unshared Q294 function, used as the golden reference for share recombination.
    function automatic nibble_t q294_ref(input nibble_t x);
        nibble_t y;
        y[0] = x[0] ^ x[3];
        y[1] = x[1];
        y[2] = x[2] ^ (x[0] & x[1]) ^ (x[1] & x[3]);
        y[3] = x[3] ^ (x[0] & x[2]) ^ (x[2] & x[3]);
        return y;
    endfunction

    // Q294 share component: linear and same-share quadratic terms come from a,
    // cross terms pair a with the next share b. Summing C over the cyclic share
    // pairs reproduces every product term of the unshared function exactly once.
    function automatic nibble_t q294_share(input nibble_t a, input nibble_t b);
        nibble_t y;
        y[0] = a[0] ^ a[3];
        y[1] = a[1];
        y[2] = a[2] ^ (a[0] & a[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0])
                    ^ (a[1] & a[3]) ^ (a[1] & b[3]) ^ (a[3] & b[1]);
        y[3] = a[3] ^ (a[0] & a[2]) ^ (a[0] & b[2]) ^ (a[2] & b[0])
                    ^ (a[2] & a[3]) ^ (a[2] & b[3]) ^ (a[3] & b[2]);
        return y;
    endfunction

endpackage

// File: rtl/ti_q294_nibble.sv
// One nibble of the quadratic TI layer: three Q294 share components with the
// cyclic share mapping (1,2), (2,3), (3,1). Each output share sees only two of
// the three input shares, which keeps the layer non-complete.
module ti_q294_nibble
    import ti_prince_pkg::*;
(
    input  nibble_t x1,
    input  nibble_t x2,
    input  nibble_t x3,
    output nibble_t y1,
    output nibble_t y2,
    output nibble_t y3
);

    assign y1 = q294_share(x1, x2);
    assign y2 = q294_share(x2, x3);
    assign y3 = q294_share(x3, x1);

endmodule

// File: rtl/ti_quad_layer_pipe.sv
// Pipelined 3-share Q294 quadratic TI layer with valid/ready handshaking.
// PIPE=1 registers only the component outputs (the glitch-stopping register);
// PIPE=2 adds an input register ahead of the component logic. The ready chain
// is combinational through the stages, with no skid buffer.
// Optional feature: define TI_REFRESH_EN to add r1/r2 ports and re-mask the
// component outputs with fresh randomness before the output register.
module ti_quad_layer_pipe
    import ti_prince_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int PIPE    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] x1,
    input  logic [NIBBLE_W*NIBBLES-1:0] x2,
    input  logic [NIBBLE_W*NIBBLES-1:0] x3,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] y1,
    output logic [NIBBLE_W*NIBBLES-1:0] y2,
    output logic [NIBBLE_W*NIBBLES-1:0] y3,
    output logic [15:0]                 beat_cnt
`ifdef TI_REFRESH_EN
    ,
    input  logic [NIBBLE_W*NIBBLES-1:0] r1,
    input  logic [NIBBLE_W*NIBBLES-1:0] r2
`endif
);

    localparam int W = NIBBLE_W * NIBBLES;

    logic [W-1:0] cx1, cx2, cx3;
    logic [W-1:0] cy1, cy2, cy3;
    logic [W-1:0] dy1, dy2, dy3;
    logic         comp_valid;
    logic         out_load;

    generate
        if ((PIPE < 1) || (PIPE > 2) || (NIBBLES < 1)) begin : g_bad_params
            $fatal(1, "ti_quad_layer_pipe: PIPE must be 1 or 2 and NIBBLES at least 1");
        end
    endgenerate

    assign out_load = !out_valid || out_ready;

    generate
        if (PIPE == 2) begin : g_in_reg
            logic         v_in;
            logic [W-1:0] s1, s2, s3;

            // Input stage: accept a beat whenever it is empty or its beat moves on.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_in <= 1'b0;
                    s1   <= '0;
                    s2   <= '0;
                    s3   <= '0;
                end else if (in_ready) begin
                    v_in <= in_valid;
                    if (in_valid) begin
                        s1 <= x1;
                        s2 <= x2;
                        s3 <= x3;
                    end
                end
            end

            assign in_ready   = !v_in || out_load;
            assign comp_valid = v_in;
            assign cx1        = s1;
            assign cx2        = s2;
            assign cx3        = s3;
        end else begin : g_no_in_reg
            assign in_ready   = out_load;
            assign comp_valid = in_valid;
            assign cx1        = x1;
            assign cx2        = x2;
            assign cx3        = x3;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
            ti_q294_nibble u_nib (
                .x1 (cx1[NIBBLE_W*i +: NIBBLE_W]),
                .x2 (cx2[NIBBLE_W*i +: NIBBLE_W]),
                .x3 (cx3[NIBBLE_W*i +: NIBBLE_W]),
                .y1 (cy1[NIBBLE_W*i +: NIBBLE_W]),
                .y2 (cy2[NIBBLE_W*i +: NIBBLE_W]),
                .y3 (cy3[NIBBLE_W*i +: NIBBLE_W])
            );
        end
    endgenerate

`ifdef TI_REFRESH_EN
    assign dy1 = cy1 ^ r1;
    assign dy2 = cy2 ^ r2;
    assign dy3 = cy3 ^ r1 ^ r2;
`else
    assign dy1 = cy1;
    assign dy2 = cy2;
    assign dy3 = cy3;
`endif

    // Output stage: glitch-stopping register fed only by the component outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y1        <= '0;
            y2        <= '0;
            y3        <= '0;
        end else if (out_load) begin
            out_valid <= comp_valid;
            if (comp_valid) begin
                y1 <= dy1;
                y2 <= dy2;
                y3 <= dy3;
            end
        end
    end

    // Count accepted output beats, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ti_quad_layer_pipe.sv
// Testbench for ti_quad_layer_pipe: one PIPE=1 and one PIPE=2 instance driven
// from a shared stimulus bus, each with its own scoreboard queue.
`timescale 1ns/1ps
module tb_ti_quad_layer_pipe;
    import ti_prince_pkg::*;

    localparam int W = 64;

`ifdef TI_REFRESH_EN
    localparam logic [3:0] RM1 = 4'hF;
    localparam logic [3:0] RM2 = 4'hF;
`else
    localparam logic [3:0] RM1 = 4'h0;
    localparam logic [3:0] RM2 = 4'h0;
`endif

    typedef struct {
        logic [W-1:0] a, b, c;
        logic [W-1:0] e1, e2, e3;
        logic [2:0]   mask;
        int           cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inValid = 1'b0;
    int   sel = 1;
    logic [W-1:0] x1 = '0, x2 = '0, x3 = '0;
    logic outReady1 = 1'b1, outReady2 = 1'b1;
    logic iv1, iv2, ir1, ir2, ov1, ov2;
    logic [W-1:0] y11, y12, y13, y21, y22, y23;
    logic [15:0] bc1, bc2;

    logic [W-1:0] nextE1 = '0, nextE2 = '0, nextE3 = '0;
    logic [2:0]   nextMask = 3'b000;
    logic latOn1 = 1'b0, latOn2 = 1'b0;
    logic toggleEn = 1'b0;
    logic [3:0] pat = 4'b1001;
    int phase = 0;
    int cyc = 0;
    int nAsserts = 0;
    int nFails = 0;
    logic [15:0] cnt1 = '0, cnt2 = '0;
    beat_t q1[$];
    beat_t q2[$];
    logic stallPrev = 1'b0;
    logic [192:0] stallSnap = '0;

`ifdef TI_REFRESH_EN
    logic [W-1:0] rr1, rr2;
    assign rr1 = {16{RM1}};
    assign rr2 = {16{RM2}};
`endif

    assign iv1 = inValid && (sel == 1);
    assign iv2 = inValid && (sel == 2);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ti_quad_layer_pipe #(.NIBBLES(16), .PIPE(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_valid (ov1),
        .out_ready (outReady1),
        .y1        (y11),
        .y2        (y12),
        .y3        (y13),
        .beat_cnt  (bc1)
`ifdef TI_REFRESH_EN
        ,
        .r1        (rr1),
        .r2        (rr2)
`endif
    );

    ti_quad_layer_pipe #(.NIBBLES(16), .PIPE(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_valid (ov2),
        .out_ready (outReady2),
        .y1        (y21),
        .y2        (y22),
        .y3        (y23),
        .beat_cnt  (bc2)
`ifdef TI_REFRESH_EN
        ,
        .r1        (rr1),
        .r2        (rr2)
`endif
    );

    // Golden recombined output: Q294 applied per nibble to the XOR of the input shares.
    function automatic logic [W-1:0] expXor(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c);
        logic [W-1:0] s;
        logic [W-1:0] r;
        s = a ^ b ^ c;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = q294_ref(s[4*i +: 4]);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBeat(input string nm, input beat_t e, input logic [W-1:0] o1,
                             input logic [W-1:0] o2, input logic [W-1:0] o3, input int latExp);
        checkOutput({nm, "_share_xor"}, o1 ^ o2 ^ o3, expXor(e.a, e.b, e.c));
        if (e.mask[0]) checkOutput({nm, "_y1"}, o1, e.e1);
        if (e.mask[1]) checkOutput({nm, "_y2"}, o2, e.e2);
        if (e.mask[2]) checkOutput({nm, "_y3"}, o3, e.e3);
        if (latExp > 0) checkOutput({nm, "_latency"}, cyc - e.cyc, latExp);
    endtask

    // Scoreboard for the PIPE=1 instance: pop on output transfer, push on input transfer.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            q1.delete();
            cnt1 = '0;
        end else begin
            checkOutput("beat_cnt1", bc1, cnt1);
            if (ov1 && outReady1) begin
                checkOutput("beat1_expected", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    checkBeat("dut1", e, y11, y12, y13, latOn1 ? 1 : 0);
                end
                cnt1 = cnt1 + 16'd1;
            end
            if (iv1 && ir1) begin
                e = '{a: x1, b: x2, c: x3, e1: nextE1, e2: nextE2, e3: nextE3,
                      mask: nextMask, cyc: cyc};
                q1.push_back(e);
            end
        end
    end

    // Scoreboard for the PIPE=2 instance, plus hold checks while downstream stalls.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            q2.delete();
            cnt2 = '0;
            stallPrev = 1'b0;
        end else begin
            checkOutput("beat_cnt2", bc2, cnt2);
            if (stallPrev) checkOutput("stall_hold2", {ov2, y21, y22, y23}, stallSnap);
            stallPrev = ov2 && !outReady2;
            stallSnap = {ov2, y21, y22, y23};
            if (ov2 && outReady2) begin
                checkOutput("beat2_expected", q2.size() > 0, 1);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    checkBeat("dut2", e, y21, y22, y23, latOn2 ? 2 : 0);
                end
                cnt2 = cnt2 + 16'd1;
            end
            if (iv2 && ir2) begin
                e = '{a: x1, b: x2, c: x3, e1: nextE1, e2: nextE2, e3: nextE3,
                      mask: nextMask, cyc: cyc};
                q2.push_back(e);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
        if (toggleEn) begin
            outReady2 = pat[phase];
            phase = (phase + 1) % 4;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        logic acc;
        acc = 1'b0;
        inValid = 1'b1;
        x1 = a;
        x2 = b;
        x3 = c;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = (sel == 1) ? ir1 : ir2;
            nextCycle();
            if (acc) return;
        end
        checkOutput("accept_timeout", acc, 1);
    endtask

    task automatic drain(input int which);
        int guard;
        guard = 0;
        inValid = 1'b0;
        while (((which == 1) ? q1.size() : q2.size()) != 0 && guard < 100) begin
            nextCycle();
            guard++;
        end
        checkOutput((which == 1) ? "drain1" : "drain2", (which == 1) ? q1.size() : q2.size(), 0);
    endtask

    initial begin
        $display("[TB] start");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rst_out_valid1", ov1, 0);
            checkOutput("rst_out_valid2", ov2, 0);
            checkOutput("rst_in_ready1", ir1, 1);
            checkOutput("rst_in_ready2", ir2, 1);
            checkOutput("rst_beat_cnt1", bc1, 0);
            checkOutput("rst_beat_cnt2", bc2, 0);
            nextCycle();
        end

        $display("[TB] PIPE=1 random beats");
        sel = 1;
        latOn1 = 1'b1;
        for (int i = 0; i < 256; i++)
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        drain(1);
        latOn1 = 1'b0;
        @(negedge clk);
        checkOutput("beat_cnt_256", bc1, 256);
        nextCycle();

        $display("[TB] direct shares and non-completeness");
        nextMask = 3'b111;
        nextE1 = {16{4'hF ^ RM1}};
        nextE2 = {16{4'h0 ^ RM2}};
        nextE3 = {16{RM1 ^ RM2}};
        applyStimulus({16{4'hA}}, '0, '0);
        for (int s = 0; s < 3; s++) begin
            for (int v = 0; v < 16; v++) begin
                logic [3:0] n;
                n = v[3:0];
                if (s == 0) begin
                    nextMask = 3'b001;
                    nextE1 = {16{4'h1 ^ RM1}};
                    applyStimulus({16{4'h5}}, {16{4'h3}}, {16{n}});
                end else if (s == 1) begin
                    nextMask = 3'b010;
                    nextE2 = {16{4'hB ^ RM2}};
                    applyStimulus({16{n}}, {16{4'h3}}, {16{4'h5}});
                end else begin
                    nextMask = 3'b100;
                    nextE3 = {16{4'h1 ^ RM1 ^ RM2}};
                    applyStimulus({16{4'h3}}, {16{n}}, {16{4'h5}});
                end
            end
        end
        drain(1);
        nextMask = 3'b000;

        $display("[TB] PIPE=2 free-flowing beats");
        sel = 2;
        outReady2 = 1'b1;
        latOn2 = 1'b1;
        for (int i = 0; i < 32; i++)
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        drain(2);
        latOn2 = 1'b0;

        $display("[TB] PIPE=2 with downstream stalls");
        phase = 0;
        toggleEn = 1'b1;
        for (int i = 0; i < 40; i++)
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        drain(2);
        toggleEn = 1'b0;
        outReady2 = 1'b1;
        nextCycle();

        $display("[TB] reset with beats in flight");
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        inValid = 1'b0;
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid2", ov2, 0);
        checkOutput("midrst_beat_cnt2", bc2, 0);
        checkOutput("midrst_beat_cnt1", bc1, 0);
        checkOutput("midrst_in_ready2", ir2, 1);
        nextCycle();
        nextMask = 3'b111;
        nextE1 = {16{4'hF ^ RM1}};
        nextE2 = {16{4'h0 ^ RM2}};
        nextE3 = {16{RM1 ^ RM2}};
        applyStimulus({16{4'hA}}, '0, '0);
        drain(2);
        nextMask = 3'b000;
        @(negedge clk);
        checkOutput("post_rst_beat_cnt2", bc2, 1);
        nextCycle();

        $display("[TB] beat counter wrap");
        sel = 1;
        for (int i = 0; i < 65535; i++)
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        drain(1);
        @(negedge clk);
        checkOutput("beat_cnt_max", bc1, 16'hFFFF);
        nextCycle();
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        drain(1);
        @(negedge clk);
        checkOutput("beat_cnt_wrap", bc1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
